fetch_decode_sequencer: RTL and testbench

- Control stage directly upstream of the datapath registers (AR, PC, IR).
- Holds the start/stop flip-flop S and the sequence counter SC, and decodes SC into one-hot timing signals T0..T15.
- Generates the fetch/decode micro-operation strobes that drive the registers' load_in/increment_in inputs and the common-bus select.
- Latches opcode decode D0..D7 and indirect bit I for the execute stage.

---
 rtl/mano_pkg.sv | 19 +
 rtl/timing_decoder.sv | 12 +
 rtl/fetch_decode_sequencer.sv | 72 +++++++
 tb/tb_fetch_decode_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// mano_pkg: shared bus codes and instruction field positions for the basic computer
package mano_pkg;
    typedef enum logic [2:0] {
        NONE   = 3'd0,
        AR     = 3'd1,
        PC     = 3'd2,
        DR     = 3'd3,
        AC     = 3'd4,
        IR     = 3'd5,
        TR     = 3'd6,
        MEMORY = 3'd7
    } bus_select_t;
    localparam int OPCODE_MSB   = 14;
    localparam int OPCODE_LSB   = 12;
    localparam int INDIRECT_BIT = 15;
    localparam int T_FETCH_AR   = 0;
    localparam int T_FETCH_IR   = 1;
    localparam int T_DECODE     = 2;
endpackage

// File: rtl/timing_decoder.sv
// timing_decoder: one-hot decode of the sequence counter, gated by an enable
module timing_decoder #(
    parameter int SC_BITS = 4
) (
    input  logic [SC_BITS-1:0]      sc,
    input  logic                    enable,
    output logic [2**SC_BITS-1:0]   timing
);
    localparam int N = 2**SC_BITS;
    // all zeros while stopped, otherwise exactly one bit set
    always_comb timing = enable ? (N'(1) << sc) : '0;
endmodule

// File: rtl/fetch_decode_sequencer.sv
// fetch_decode_sequencer: start/stop flag, sequence counter, timing signals, fetch strobes and opcode latch
module fetch_decode_sequencer
    import mano_pkg::*;
#(
    parameter int WORD_BITS = 16,
    parameter int SC_BITS   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start_in,
    input  logic                    halt_in,
    input  logic                    sc_clear_in,
    input  logic [WORD_BITS-1:0]    ir_in,
    output logic                    running_out,
    output logic [SC_BITS-1:0]      sc_out,
    output logic [2**SC_BITS-1:0]   timing_out,
    output logic [2:0]              bus_select_out,
    output logic                    memory_read_out,
    output logic                    ar_load_out,
    output logic                    pc_increment_out,
    output logic                    ir_load_out,
    output logic [7:0]              decode_out,
    output logic                    indirect_out
);
    logic                   running;
    logic [SC_BITS-1:0]     sc;
    logic [2**SC_BITS-1:0]  timing;
    bus_select_t            bus;
    logic                   unused_ir;

    assign unused_ir = ^ir_in;

    timing_decoder #(.SC_BITS(SC_BITS)) u_timing (
        .sc     (sc),
        .enable (running),
        .timing (timing)
    );

    // S flag: halt wins over start, otherwise hold
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) running <= 1'b0;
        else if (halt_in) running <= 1'b0;
        else if (start_in) running <= 1'b1;

    // sequence counter: clear beats count, counts only while running, wraps naturally
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) sc <= '0;
        else if (halt_in || sc_clear_in) sc <= '0;
        else if (running) sc <= sc + 1'b1;

    // opcode/indirect latch loads at the end of T2 even if the counter is being cleared
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            decode_out   <= 8'h00;
            indirect_out <= 1'b0;
        end else if (timing[T_DECODE]) begin
            decode_out   <= 8'h01 << ir_in[OPCODE_MSB:OPCODE_LSB];
            indirect_out <= ir_in[INDIRECT_BIT];
        end

    // fetch micro-operations: AR<-PC at T0, IR<-M[AR] and PC++ at T1, AR<-IR at T2
    always_comb bus = timing[T_FETCH_AR] ? PC : timing[T_FETCH_IR] ? MEMORY : timing[T_DECODE] ? IR : NONE;

    assign running_out      = running;
    assign sc_out           = sc;
    assign timing_out       = timing;
    assign bus_select_out   = bus;
    assign ar_load_out      = timing[T_FETCH_AR] | timing[T_DECODE];
    assign memory_read_out  = timing[T_FETCH_IR];
    assign ir_load_out      = timing[T_FETCH_IR];
    assign pc_increment_out = timing[T_FETCH_IR];
endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// tb_fetch_decode_sequencer: directed stimulus checked against a cycle model of the sequencer
module tb_fetch_decode_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_in = 1'b0;
    logic        halt_in = 1'b0;
    logic        sc_clear_in = 1'b0;
    logic [15:0] ir_in = 16'h0000;
    logic        running_out;
    logic [3:0]  sc_out;
    logic [15:0] timing_out;
    logic [2:0]  bus_select_out;
    logic        memory_read_out, ar_load_out, pc_increment_out, ir_load_out;
    logic [7:0]  decode_out;
    logic        indirect_out;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;

    logic       m_s;
    int         m_sc;
    logic [7:0] m_dec;
    logic       m_ind;

    fetch_decode_sequencer #(.WORD_BITS(16), .SC_BITS(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start_in         (start_in),
        .halt_in          (halt_in),
        .sc_clear_in      (sc_clear_in),
        .ir_in            (ir_in),
        .running_out      (running_out),
        .sc_out           (sc_out),
        .timing_out       (timing_out),
        .bus_select_out   (bus_select_out),
        .memory_read_out  (memory_read_out),
        .ar_load_out      (ar_load_out),
        .pc_increment_out (pc_increment_out),
        .ir_load_out      (ir_load_out),
        .decode_out       (decode_out),
        .indirect_out     (indirect_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // reference behaviour: S, SC and the decode latch as the rules describe them
    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            m_s   <= 1'b0;
            m_sc  <= 0;
            m_dec <= 8'h00;
            m_ind <= 1'b0;
        end else begin
            if (m_s && m_sc == 2) begin
                m_dec <= 8'd1 << ir_in[14:12];
                m_ind <= ir_in[15];
            end
            m_sc <= (halt_in || sc_clear_in) ? 0 : m_s ? (m_sc + 1) % 16 : m_sc;
            m_s  <= halt_in ? 1'b0 : start_in ? 1'b1 : m_s;
        end

    // every cycle: outputs versus the model
    always @(negedge clock)
        if (check_en) begin
            logic [15:0] et;
            logic [2:0]  eb;
            int ph;
            ph = m_s ? m_sc : -1;
            et = m_s ? (16'(1) << m_sc) : 16'h0000;
            eb = ph == 0 ? 3'd2 : ph == 1 ? 3'd7 : ph == 2 ? 3'd5 : 3'd0;
            chk("m_running", 32'(running_out), 32'(m_s));
            chk("m_sc", 32'(sc_out), 32'(m_sc));
            chk("m_timing", 32'(timing_out), 32'(et));
            chk("m_bus", 32'(bus_select_out), 32'(eb));
            chk("m_ar_load", 32'(ar_load_out), 32'(ph == 0 || ph == 2));
            chk("m_mem_read", 32'(memory_read_out), 32'(ph == 1));
            chk("m_ir_load", 32'(ir_load_out), 32'(ph == 1));
            chk("m_pc_inc", 32'(pc_increment_out), 32'(ph == 1));
            chk("m_decode", 32'(decode_out), 32'(m_dec));
            chk("m_indirect", 32'(indirect_out), 32'(m_ind));
        end

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        check_en = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("idle_running", 32'(running_out), 0);
            chk("idle_sc", 32'(sc_out), 0);
            chk("idle_timing", 32'(timing_out), 0);
            chk("idle_decode", 32'(decode_out), 0);
        end
        tick();
        start_in = 1'b1;
        ir_in = 16'hB123;
        tick();
        start_in = 1'b0;
        @(negedge clock);
        chk("t0_timing", 32'(timing_out), 32'h0001);
        chk("t0_bus", 32'(bus_select_out), 2);
        chk("t0_ar_load", 32'(ar_load_out), 1);
        tick();
        @(negedge clock);
        chk("t1_timing", 32'(timing_out), 32'h0002);
        chk("t1_bus", 32'(bus_select_out), 7);
        chk("t1_strobes", 32'({memory_read_out, ir_load_out, pc_increment_out, ar_load_out}), 32'b1110);
        tick();
        @(negedge clock);
        chk("t2_timing", 32'(timing_out), 32'h0004);
        chk("t2_bus", 32'(bus_select_out), 5);
        chk("t2_ar_load", 32'(ar_load_out), 1);
        tick();
        @(negedge clock);
        chk("b123_decode", 32'(decode_out), 32'h08);
        chk("b123_indirect", 32'(indirect_out), 1);
        chk("b123_sc", 32'(sc_out), 3);
        tick();
        tick();
        sc_clear_in = 1'b1;
        ir_in = 16'h7001;
        tick();
        sc_clear_in = 1'b0;
        @(negedge clock);
        chk("clr_sc", 32'(sc_out), 0);
        chk("clr_timing", 32'(timing_out), 32'h0001);
        repeat (3) tick();
        @(negedge clock);
        chk("7001_decode", 32'(decode_out), 32'h80);
        chk("7001_indirect", 32'(indirect_out), 0);
        repeat (12) tick();
        @(negedge clock);
        chk("wrap_sc15", 32'(sc_out), 15);
        chk("wrap_t15", 32'(timing_out), 32'h8000);
        chk("wrap_t15_bus", 32'(bus_select_out), 0);
        tick();
        @(negedge clock);
        chk("wrap_sc0", 32'(sc_out), 0);
        chk("wrap_t0_bus", 32'(bus_select_out), 2);
        repeat (4) tick();
        start_in = 1'b1;
        halt_in = 1'b1;
        tick();
        start_in = 1'b0;
        halt_in = 1'b0;
        @(negedge clock);
        chk("halt_running", 32'(running_out), 0);
        chk("halt_sc", 32'(sc_out), 0);
        chk("halt_timing", 32'(timing_out), 0);
        repeat (2) tick();
        @(negedge clock);
        chk("halt_hold_decode", 32'(decode_out), 32'h80);
        tick();
        start_in = 1'b1;
        ir_in = 16'hB123;
        tick();
        start_in = 1'b0;
        @(negedge clock);
        chk("resume_timing", 32'(timing_out), 32'h0001);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_running", 32'(running_out), 0);
        chk("arst_sc", 32'(sc_out), 0);
        chk("arst_timing", 32'(timing_out), 0);
        chk("arst_strobes", 32'({bus_select_out, memory_read_out, ar_load_out, pc_increment_out, ir_load_out}), 0);
        chk("arst_decode", 32'(decode_out), 0);
        chk("arst_indirect", 32'(indirect_out), 0);
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_decode", 32'(decode_out), 0);
            chk("post_running", 32'(running_out), 0);
        end
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
